// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions for the ID/EX issue stage.
// Contents: ALU control codes, opcode and funct constants, the skid-buffer
// state encoding and the packed entry type held in the head/skid registers.
package mips_defs;

  localparam int DATA_W = 32;
  localparam int ALU_W  = 3;

  // ALU control codes understood by alu_32bit
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [ALU_W-1:0]  alu_ctr;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic              illegal;
  } entry_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_decode.sv
// alu_decode: purely combinational instruction decode for the ID/EX stage.
// Ports:
//   instr_i     instruction word
//   rs_data_i   register-file value of rs
//   rt_data_i   register-file value of rt
//   alu_a_o, alu_b_o, alu_ctr_o   ALU operands and control code
//   dest_reg_o, reg_write_o       write-back target and enable
//   illegal_o                     instruction could not be decoded
module alu_decode
  import mips_defs::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [2:0]  alu_ctr_o,
  output logic [4:0]  dest_reg_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  logic [5:0]  opcode;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instr_i[31:26];
  assign rt_f   = instr_i[20:16];
  assign rd_f   = instr_i[15:11];
  assign funct  = instr_i[5:0];
  assign imm    = instr_i[15:0];

  // rs index and shamt are not needed: operands arrive already read
  logic unused_fields;
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    alu_a_o     = rs_data_i;
    alu_b_o     = rt_data_i;
    alu_ctr_o   = ALU_AND;
    dest_reg_o  = 5'd0;
    reg_write_o = 1'b0;
    illegal_o   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dest_reg_o  = rd_f;
        reg_write_o = (rd_f != 5'd0);
        case (funct)
          FN_AND:  alu_ctr_o = ALU_AND;
          FN_OR:   alu_ctr_o = ALU_OR;
          FN_ADD:  alu_ctr_o = ALU_ADD;
          FN_SUB:  alu_ctr_o = ALU_SUB;
          FN_XOR:  alu_ctr_o = ALU_XOR;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        dest_reg_o  = rt_f;
        reg_write_o = (rt_f != 5'd0);
        case (opcode)
          OP_ADDI: begin alu_ctr_o = ALU_ADD; alu_b_o = sext16(imm); end
          OP_ANDI: begin alu_ctr_o = ALU_AND; alu_b_o = zext16(imm); end
          OP_ORI:  begin alu_ctr_o = ALU_OR;  alu_b_o = zext16(imm); end
          default: begin alu_ctr_o = ALU_XOR; alu_b_o = zext16(imm); end
        endcase
      end
      OP_BEQ:  alu_ctr_o = ALU_SUB;
      default: illegal_o = 1'b1;
    endcase
    // Undecodable entries are issued with every payload field zeroed
    if (illegal_o) begin
      alu_a_o     = 32'd0;
      alu_b_o     = 32'd0;
      alu_ctr_o   = ALU_AND;
      dest_reg_o  = 5'd0;
      reg_write_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-and-issue stage feeding alu_32bit.
// Decodes one instruction per cycle into a two-entry skid buffer (head =
// output register, skid = second entry) with valid/ready on both sides.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake (in_ready registered)
//   instr, rs_data, rt_data         instruction and its register operands
//   flush                           synchronous kill of all held entries
//   out_valid/out_ready             downstream handshake
//   alu_a, alu_b, alu_ctr           ALU operands and control code
//   dest_reg, reg_write, illegal    write-back info and decode-error flag
module id_ex_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal
);

  entry_t      dec;
  entry_t      head_q, head_d, skid_q;
  skid_state_e state_q, state_d;
  logic        in_ready_q, out_valid_q;
  logic        head_load, skid_load;
  logic        accept, consume;

  alu_decode u_dec (
    .instr_i     (instr),
    .rs_data_i   (rs_data),
    .rt_data_i   (rt_data),
    .alu_a_o     (dec.alu_a),
    .alu_b_o     (dec.alu_b),
    .alu_ctr_o   (dec.alu_ctr),
    .dest_reg_o  (dec.dest_reg),
    .reg_write_o (dec.reg_write),
    .illegal_o   (dec.illegal)
  );

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = dec;
    head_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) begin
          head_load = 1'b1;
          state_d   = ST_ONE;
        end
        ST_ONE: begin
          if (accept && consume) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (consume) begin
            state_d   = ST_EMPTY;
          end
        end
        ST_TWO: if (consume) begin
          head_d    = skid_q;
          head_load = 1'b1;
          state_d   = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry registers: handshake flags are registered from the next state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      if (head_load) head_q <= head_d;
      if (skid_load) skid_q <= dec;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_a     = head_q.alu_a;
  assign alu_b     = head_q.alu_b;
  assign alu_ctr   = head_q.alu_ctr;
  assign dest_reg  = head_q.dest_reg;
  assign reg_write = head_q.reg_write;
  assign illegal   = head_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctr;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        illegal;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .dest_reg  (dest_reg),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctr;
    logic [4:0]  dest;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_act, mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] ctr, input logic [4:0] dest,
                              input logic rw, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.ctr = ctr; e.dest = dest; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      mon_act = {alu_a, alu_b, alu_ctr, dest_reg, reg_write, illegal};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got a=%h b=%h ctr=%b dest=%0d rw=%b ill=%b, required none",
                 mon_act.a, mon_act.b, mon_act.ctr, mon_act.dest, mon_act.rw, mon_act.ill);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL out_entry: got a=%h b=%h ctr=%b dest=%0d rw=%b ill=%b, required a=%h b=%h ctr=%b dest=%0d rw=%b ill=%b",
                   mon_act.a, mon_act.b, mon_act.ctr, mon_act.dest, mon_act.rw, mon_act.ill,
                   mon_exp.a, mon_exp.b, mon_exp.ctr, mon_exp.dest, mon_exp.rw, mon_exp.ill);
        end
      end
    end
  end

  // Drive one instruction and hold it until accepted (bounded)
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input bit push, input exp_t e);
    bit acc;
    instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
    if (push) sb_q.push_back(e);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_alu_a", alu_a, 32'd0);
    check32("rst_alu_b", alu_b, 32'd0);
    check32("rst_ctl", {24'd0, alu_ctr, dest_reg}, 32'd0);
    check32("rst_flags", {30'd0, reg_write, illegal}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Streaming decode with downstream always ready
    out_ready = 1'b1;
    send(rtype(1, 2, 5, 6'h20), 32'd10, 32'd30, 1, mk(32'd10, 32'd30, 3'b010, 5'd5, 1'b1, 1'b0));
    check32("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check32("lat_alu_a", alu_a, 32'd10);
    check32("lat_alu_ctr", {29'd0, alu_ctr}, 32'd2);
    send(itype(6'b001000, 3, 4, 16'hFFFF), 32'd100, 32'd7, 1,
         mk(32'd100, 32'hFFFF_FFFF, 3'b010, 5'd4, 1'b1, 1'b0));
    send(itype(6'b001100, 3, 6, 16'hFFFF), 32'h1234_5678, 32'd7, 1,
         mk(32'h1234_5678, 32'h0000_FFFF, 3'b000, 5'd6, 1'b1, 1'b0));
    send(itype(6'b001101, 1, 0, 16'h00F0), 32'h0F, 32'd99, 1,
         mk(32'h0F, 32'hF0, 3'b001, 5'd0, 1'b0, 1'b0));
    send(rtype(1, 2, 0, 6'h22), 32'd50, 32'd8, 1, mk(32'd50, 32'd8, 3'b110, 5'd0, 1'b0, 1'b0));
    send(itype(6'b000100, 1, 2, 16'h0010), 32'd7, 32'd7, 1, mk(32'd7, 32'd7, 3'b110, 5'd0, 1'b0, 1'b0));
    send(rtype(1, 2, 3, 6'b101010), 32'd5, 32'd6, 1, mk(32'd0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b1));
    send(itype(6'b100011, 1, 2, 16'h0004), 32'd5, 32'd6, 1, mk(32'd0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b1));
    check32("illegal_out_valid", {31'd0, out_valid}, 32'd1);
    send(rtype(1, 2, 9, 6'h26), 32'd20, 32'd20, 1, mk(32'd20, 32'd20, 3'b111, 5'd9, 1'b1, 1'b0));
    send(rtype(3, 4, 31, 6'h25), 32'hA0, 32'h0B, 1, mk(32'hA0, 32'h0B, 3'b001, 5'd31, 1'b1, 1'b0));
    send(rtype(3, 4, 12, 6'h24), 32'hF0F0, 32'hFF00, 1, mk(32'hF0F0, 32'hFF00, 3'b000, 5'd12, 1'b1, 1'b0));
    send(itype(6'b001110, 2, 8, 16'h8000), 32'd1, 32'd0, 1, mk(32'd1, 32'h0000_8000, 3'b111, 5'd8, 1'b1, 1'b0));
    send(itype(6'b001000, 2, 10, 16'h7FFF), 32'd5, 32'd0, 1, mk(32'd5, 32'h0000_7FFF, 3'b010, 5'd10, 1'b1, 1'b0));
    idle(3);

    // Back-pressure: three back-to-back instructions with the sink stalled
    out_ready = 1'b0;
    send(rtype(1, 2, 3, 6'h20), 32'd11, 32'd22, 1, mk(32'd11, 32'd22, 3'b010, 5'd3, 1'b1, 1'b0));
    check32("bp_in_ready_one", {31'd0, in_ready}, 32'd1);
    send(rtype(1, 2, 4, 6'h22), 32'd40, 32'd15, 1, mk(32'd40, 32'd15, 3'b110, 5'd4, 1'b1, 1'b0));
    check32("bp_in_ready_two", {31'd0, in_ready}, 32'd0);
    fork
      send(rtype(1, 2, 5, 6'h25), 32'd3, 32'd4, 1, mk(32'd3, 32'd4, 3'b001, 5'd5, 1'b1, 1'b0));
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check32("bp_head_stable_a", alu_a, 32'd11);
          check32("bp_head_stable_b", alu_b, 32'd22);
          check32("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check32("bp_in_ready_after_consume", {31'd0, in_ready}, 32'd1);
        check32("bp_head_is_second", alu_a, 32'd40);
      end
    join
    idle(3);

    // Flush with two entries held and a simultaneous input offer
    out_ready = 1'b0;
    send(rtype(1, 2, 6, 6'h20), 32'd1, 32'd2, 0, mk(0, 0, 0, 0, 0, 0));
    send(rtype(1, 2, 7, 6'h20), 32'd3, 32'd4, 0, mk(0, 0, 0, 0, 0, 0));
    check32("fl_pre_in_ready", {31'd0, in_ready}, 32'd0);
    instr = rtype(1, 2, 8, 6'h20); rs_data = 32'd5; rt_data = 32'd6;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    check32("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check32("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("fl_stays_empty", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(itype(6'b001101, 1, 7, 16'h1234), 32'd0, 32'd0, 1, mk(32'd0, 32'h1234, 3'b001, 5'd7, 1'b1, 1'b0));
    idle(3);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(rtype(1, 2, 2, 6'h20), 32'd77, 32'd1, 0, mk(0, 0, 0, 0, 0, 0));
    check32("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check32("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check32("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check32("ar_alu_a", alu_a, 32'd0);
    check32("ar_alu_b", alu_b, 32'd0);
    check32("ar_ctl", {22'd0, alu_ctr, dest_reg, reg_write, illegal}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(rtype(1, 2, 3, 6'h26), 32'hFF, 32'h0F, 1, mk(32'hFF, 32'h0F, 3'b111, 5'd3, 1'b1, 1'b0));
    idle(4);

    check32("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
